lc3_control_unit: RTL
=====================

LC3_CONTROL_UNIT -- requirements
Module: lc3_control_unit

Interface
REQ-001 Parameter MEM_WAIT, default 3, memory-access cycles per read/write in fixed-latency mode; legal range 1..15.
REQ-002 Parameter USE_READY, default 0, 1 = memory access ends on Mem_Ready instead of the MEM_WAIT count.
REQ-003 Parameter PAUSE_EN, default 1, 0 = opcode 1101 decodes as NOP (returns to fetch).
REQ-004 Clk  in  1  clock; Reset  in  1  reset, synchronous, active-high.
REQ-005 Run  in  1  leave HALTED; Continue  in  1  pause release.
REQ-006 Opcode  in  4  IR[15:12]; IR_5, IR_11, BEN  in  1 each  mode bits / branch enable.
REQ-007 Mem_Ready  in  1  memory done (used only when USE_READY=1).
REQ-008 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
REQ-009 GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle.
REQ-010 PCMUX  out  2  00 PC+1, 01 bus, 10 adder; ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11; ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA.
REQ-011 DRMUX  out  1  1 = R7; SR1MUX  out  1  1 = IR[8:6]; SR2MUX, ADDR1MUX (1 = SR1)  out  1; MARMUX  out  1  1 = ZEXT(IR[7:0]).
REQ-012 Mem_OE, Mem_WE  out  1 each  active-high memory strobes; never high together.
REQ-013 Busy  out  1  high in every state except HALTED and PAUSE states.

Function
REQ-014 Every output SHALL default to 0 in each state unless the state asserts it.
REQ-015 Fetch: F_MAR (MAR<-PC, PC<-PC+1), F_MEM (Mem_OE, LD_MDR), F_IR (GateMDR, LD_IR), DECODE (LD_BEN).
REQ-016 All memory states SHALL share one wait counter: fixed mode holds the state exactly MEM_WAIT cycles; ready mode holds it until the first cycle Mem_Ready=1, inclusive. Counter clears on every state entry.
REQ-017 Decode: 0001 ADD, 0101 AND, 1001 NOT, 0110 LDR, 0111 STR, 0010 LD, 1010 LDI, 0011 ST, 1011 STI, 1110 LEA, 0100 JSR, 1100 JMP, 0000 BR, 1111 TRAP, 1101 PAUSE; 1000 and undefined -> F_MAR.
REQ-018 ADD/AND/NOT: one cycle, SR2MUX=IR_5, SR1MUX=1, GateALU, LD_REG, LD_CC.
REQ-019 LDR/STR address: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01; LD/ST/LDI/STI address: ADDR1MUX=0, ADDR2MUX=10; all via GateMARMUX, LD_MAR.
REQ-020 Loads: address -> MEM read -> WB (GateMDR, LD_REG, LD_CC). LDI inserts MEM read -> MAR<-MDR (GateMDR, LD_MAR) before the final read.
REQ-021 Stores: address -> MDR<-SR (SR1MUX=0, ALUK=11, GateALU, LD_MDR) -> MEM write (Mem_WE). STI inserts indirect read plus MAR<-MDR first.
REQ-022 LEA: one cycle, ADDR2MUX=10, GateMARMUX, LD_REG, no LD_CC.
REQ-023 JSR: R7<-PC (DRMUX=1, GatePC, LD_REG), then PC<-PC+off11 if IR_11=1, else PC<-SR1 (ADDR1MUX=1, ADDR2MUX=00, SR1MUX=1); PCMUX=10.
REQ-024 JMP: PC<-SR1 as in REQ-023; BR: BEN=1 -> PC<-PC+off9, BEN=0 -> F_MAR.
REQ-025 TRAP: R7<-PC; MAR<-ZEXT (MARMUX=1, GateMARMUX, LD_MAR); MEM read; PC<-MDR (GateMDR, PCMUX=01, LD_PC).
REQ-026 PAUSE: P1 asserts LD_LED, waits for Continue=1; P2 waits for Continue=0, then F_MAR.
REQ-027 Every instruction SHALL end by entering F_MAR; HALTED is reachable only via Reset.
REQ-028 Run is ignored outside HALTED; Mem_Ready is ignored outside memory states.

Reset
REQ-029 Reset SHALL force HALTED and clear the wait counter on the next Clk edge, mid-instruction or mid-access included; all outputs are 0 in HALTED.

Structure
REQ-030 State enum, ALUK/PCMUX/ADDR2MUX encodings and opcode constants SHALL live in package lc3_pkg.
REQ-031 The wait counter SHALL be sub-module lc3_mem_wait (start, done; MEM_WAIT, USE_READY parameters).

Verification
REQ-032 MEM_WAIT=3, Run pulse -> F_MEM Mem_OE high exactly 3 cycles, LD_IR in cycle 5 after leaving HALTED.
REQ-033 USE_READY=1, Mem_Ready after 7 cycles -> Mem_OE high 7 cycles, F_IR next.
REQ-034 LDI (1010) -> two read phases, one MAR<-MDR cycle between them, WB with LD_CC.
REQ-035 TRAP x25 -> DRMUX=1 LD_REG, MARMUX=1 LD_MAR, read, PCMUX=01 LD_PC, then F_MAR.
REQ-036 BR with BEN=0 -> DECODE, BR state, F_MAR, LD_PC never asserted; BEN=1 -> PCMUX=10, ADDR2MUX=10.
REQ-037 Reset in second STI write cycle -> HALTED next edge, Mem_WE 0, Busy 0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 control unit: FSM states, datapath
// mux selects, ALU operations and instruction opcodes.
package lc3_pkg;

  typedef enum logic [5:0] {
    S_HALTED, S_F_MAR, S_F_MEM, S_F_IR, S_DECODE,
    S_ADD, S_AND, S_NOT,
    S_LDR_A, S_LD_A, S_LDI_A, S_STR_A, S_ST_A, S_STI_A,
    S_LDI_RD, S_LDI_MAR, S_LD_RD, S_LD_WB,
    S_STI_RD, S_STI_MAR, S_ST_MDR, S_ST_WR,
    S_LEA, S_JSR_R7, S_JSR_PC, S_JMP, S_BR,
    S_TRAP_R7, S_TRAP_MAR, S_TRAP_RD, S_TRAP_PC,
    S_P1, S_P2
  } state_e;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LD    = 4'b0010;
  localparam logic [3:0] OP_ST    = 4'b0011;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_LDI   = 4'b1010;
  localparam logic [3:0] OP_STI   = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;
  localparam logic [3:0] OP_LEA   = 4'b1110;
  localparam logic [3:0] OP_TRAP  = 4'b1111;

  function automatic logic isMemState(state_e s);
    return s inside {S_F_MEM, S_LDI_RD, S_LD_RD, S_STI_RD, S_ST_WR, S_TRAP_RD};
  endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// Shared memory-access wait counter: Done_o marks the last cycle of an access,
// either after MEM_WAIT cycles or on the first Mem_Ready_i.
module lc3_mem_wait #(
  parameter int MEM_WAIT  = 3,
  parameter int USE_READY = 0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start_i,
  input  logic Mem_Ready_i,
  output logic Done_o
);

  localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

  logic [3:0] count_q, count_d;

  // The counter sits at zero outside an access, so every new access starts clean.
  always_comb begin
    if (USE_READY != 0) Done_o = Start_i & Mem_Ready_i;
    else                Done_o = Start_i & (count_q == LAST);
    count_d = count_q + 4'd1;
    if (!Start_i || Done_o) count_d = '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/lc3_control_unit.sv
// LC-3 microsequencer: fetch/decode/execute FSM producing datapath load
// enables, bus gates, mux selects and memory strobes.
module lc3_control_unit
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT  = 3,
  parameter int USE_READY = 0,
  parameter int PAUSE_EN  = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_i,
  input  logic       Continue_i,
  input  logic [3:0] Opcode_i,
  input  logic       IR_5_i,
  input  logic       IR_11_i,
  input  logic       BEN_i,
  input  logic       Mem_Ready_i,
  output logic       LD_MAR_o,
  output logic       LD_MDR_o,
  output logic       LD_IR_o,
  output logic       LD_BEN_o,
  output logic       LD_CC_o,
  output logic       LD_REG_o,
  output logic       LD_PC_o,
  output logic       LD_LED_o,
  output logic       GatePC_o,
  output logic       GateMDR_o,
  output logic       GateALU_o,
  output logic       GateMARMUX_o,
  output logic [1:0] PCMUX_o,
  output logic [1:0] ADDR2MUX_o,
  output logic [1:0] ALUK_o,
  output logic       DRMUX_o,
  output logic       SR1MUX_o,
  output logic       SR2MUX_o,
  output logic       ADDR1MUX_o,
  output logic       MARMUX_o,
  output logic       Mem_OE_o,
  output logic       Mem_WE_o,
  output logic       Busy_o
);

  state_e state_q, state_d;
  logic   memDone;

  lc3_mem_wait #(
    .MEM_WAIT (MEM_WAIT),
    .USE_READY(USE_READY)
  ) u_mem_wait (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start_i    (isMemState(state_q)),
    .Mem_Ready_i(Mem_Ready_i),
    .Done_o     (memDone)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_HALTED;
    else       state_q <= state_d;
  end

  assign Busy_o = !(state_q inside {S_HALTED, S_P1, S_P2});

  always_comb begin
    state_d      = state_q;
    LD_MAR_o     = 1'b0;
    LD_MDR_o     = 1'b0;
    LD_IR_o      = 1'b0;
    LD_BEN_o     = 1'b0;
    LD_CC_o      = 1'b0;
    LD_REG_o     = 1'b0;
    LD_PC_o      = 1'b0;
    LD_LED_o     = 1'b0;
    GatePC_o     = 1'b0;
    GateMDR_o    = 1'b0;
    GateALU_o    = 1'b0;
    GateMARMUX_o = 1'b0;
    PCMUX_o      = PCMUX_PC1;
    ADDR2MUX_o   = ADDR2_ZERO;
    ALUK_o       = ALUK_ADD;
    DRMUX_o      = 1'b0;
    SR1MUX_o     = 1'b0;
    SR2MUX_o     = 1'b0;
    ADDR1MUX_o   = 1'b0;
    MARMUX_o     = 1'b0;
    Mem_OE_o     = 1'b0;
    Mem_WE_o     = 1'b0;

    case (state_q)
      S_HALTED: if (Run_i) state_d = S_F_MAR;
      S_F_MAR: begin
        GatePC_o = 1'b1;
        LD_MAR_o = 1'b1;
        LD_PC_o  = 1'b1;
        state_d  = S_F_MEM;
      end
      S_F_MEM: begin
        Mem_OE_o = 1'b1;
        LD_MDR_o = 1'b1;
        if (memDone) state_d = S_F_IR;
      end
      S_F_IR: begin
        GateMDR_o = 1'b1;
        LD_IR_o   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        LD_BEN_o = 1'b1;
        case (Opcode_i)
          OP_ADD:   state_d = S_ADD;
          OP_AND:   state_d = S_AND;
          OP_NOT:   state_d = S_NOT;
          OP_LDR:   state_d = S_LDR_A;
          OP_STR:   state_d = S_STR_A;
          OP_LD:    state_d = S_LD_A;
          OP_LDI:   state_d = S_LDI_A;
          OP_ST:    state_d = S_ST_A;
          OP_STI:   state_d = S_STI_A;
          OP_LEA:   state_d = S_LEA;
          OP_JSR:   state_d = S_JSR_R7;
          OP_JMP:   state_d = S_JMP;
          OP_BR:    state_d = S_BR;
          OP_TRAP:  state_d = S_TRAP_R7;
          OP_PAUSE: state_d = (PAUSE_EN != 0) ? S_P1 : S_F_MAR;
          default:  state_d = S_F_MAR;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        SR1MUX_o  = 1'b1;
        SR2MUX_o  = IR_5_i;
        ALUK_o    = (state_q == S_ADD) ? ALUK_ADD : (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
        GateALU_o = 1'b1;
        LD_REG_o  = 1'b1;
        LD_CC_o   = 1'b1;
        state_d   = S_F_MAR;
      end
      S_LDR_A, S_STR_A: begin
        SR1MUX_o     = 1'b1;
        ADDR1MUX_o   = 1'b1;
        ADDR2MUX_o   = ADDR2_OFF6;
        GateMARMUX_o = 1'b1;
        LD_MAR_o     = 1'b1;
        state_d      = (state_q == S_LDR_A) ? S_LD_RD : S_ST_MDR;
      end
      S_LD_A, S_LDI_A, S_ST_A, S_STI_A: begin
        ADDR2MUX_o   = ADDR2_OFF9;
        GateMARMUX_o = 1'b1;
        LD_MAR_o     = 1'b1;
        case (state_q)
          S_LD_A:  state_d = S_LD_RD;
          S_LDI_A: state_d = S_LDI_RD;
          S_ST_A:  state_d = S_ST_MDR;
          default: state_d = S_STI_RD;
        endcase
      end
      S_LDI_RD, S_STI_RD, S_LD_RD, S_TRAP_RD: begin
        Mem_OE_o = 1'b1;
        LD_MDR_o = 1'b1;
        if (memDone) begin
          case (state_q)
            S_LDI_RD: state_d = S_LDI_MAR;
            S_STI_RD: state_d = S_STI_MAR;
            S_LD_RD:  state_d = S_LD_WB;
            default:  state_d = S_TRAP_PC;
          endcase
        end
      end
      // Indirect modes replace MAR with the pointer just read before the real access.
      S_LDI_MAR, S_STI_MAR: begin
        GateMDR_o = 1'b1;
        LD_MAR_o  = 1'b1;
        state_d   = (state_q == S_LDI_MAR) ? S_LD_RD : S_ST_MDR;
      end
      S_LD_WB: begin
        GateMDR_o = 1'b1;
        LD_REG_o  = 1'b1;
        LD_CC_o   = 1'b1;
        state_d   = S_F_MAR;
      end
      S_ST_MDR: begin
        ALUK_o    = ALUK_PASSA;
        GateALU_o = 1'b1;
        LD_MDR_o  = 1'b1;
        state_d   = S_ST_WR;
      end
      S_ST_WR: begin
        Mem_WE_o = 1'b1;
        if (memDone) state_d = S_F_MAR;
      end
      S_LEA: begin
        ADDR2MUX_o   = ADDR2_OFF9;
        GateMARMUX_o = 1'b1;
        LD_REG_o     = 1'b1;
        state_d      = S_F_MAR;
      end
      S_JSR_R7, S_TRAP_R7: begin
        DRMUX_o  = 1'b1;
        GatePC_o = 1'b1;
        LD_REG_o = 1'b1;
        state_d  = (state_q == S_JSR_R7) ? S_JSR_PC : S_TRAP_MAR;
      end
      S_JSR_PC, S_JMP: begin
        PCMUX_o = PCMUX_ADDER;
        LD_PC_o = 1'b1;
        if (state_q == S_JSR_PC && IR_11_i) begin
          ADDR2MUX_o = ADDR2_OFF11;
        end else begin
          SR1MUX_o   = 1'b1;
          ADDR1MUX_o = 1'b1;
        end
        state_d = S_F_MAR;
      end
      S_BR: begin
        if (BEN_i) begin
          PCMUX_o    = PCMUX_ADDER;
          ADDR2MUX_o = ADDR2_OFF9;
          LD_PC_o    = 1'b1;
        end
        state_d = S_F_MAR;
      end
      S_TRAP_MAR: begin
        MARMUX_o     = 1'b1;
        GateMARMUX_o = 1'b1;
        LD_MAR_o     = 1'b1;
        state_d      = S_TRAP_RD;
      end
      S_TRAP_PC: begin
        GateMDR_o = 1'b1;
        PCMUX_o   = PCMUX_BUS;
        LD_PC_o   = 1'b1;
        state_d   = S_F_MAR;
      end
      S_P1: begin
        LD_LED_o = 1'b1;
        if (Continue_i) state_d = S_P2;
      end
      S_P2: if (!Continue_i) state_d = S_F_MAR;
      default: state_d = S_HALTED;
    endcase
  end

endmodule
